bp_lce_req_arbiter: RTL

//  Shares one LCE->CCE request network port between num_req_p LCE request FSMs (e.g. I$ and D$ miss/uncached paths).

---
 rtl/bp_common_pkg.sv | 7 +
 rtl/bp_lce_req_arbiter_rr_pick.sv | 34 +++
 rtl/bp_lce_req_arbiter.sv | 96 +++++++++
 3 files changed

// File: rtl/bp_common_pkg.sv
// Shared BlackParrot definitions used to size the LCE request path.
package bp_common_pkg;

  // Packed width of one bp_lce_cce_req_s message
  localparam int bp_lce_cce_req_width_gp = 128;

endpackage

// File: rtl/bp_lce_req_arbiter_rr_pick.sv
// Round-robin priority picker: rotate elig so the slot after last_i sits at
// bit 0, priority-encode the lowest set bit, then rotate the index back.
module bp_rr_pick #(
  parameter int n_p = 2,
  localparam int id_w = $clog2(n_p)
) (
  input  logic [n_p-1:0]  elig_i,
  input  logic [id_w-1:0] last_i,
  output logic [n_p-1:0]  grant_o,
  output logic [id_w-1:0] id_o,
  output logic            any_o
);

  logic [2*n_p-1:0] dbl, sh;
  logic [n_p-1:0]   rot;
  int               base;
  int               k_sel;

  // Rotate, priority-encode, un-rotate
  always_comb begin
    base  = (int'(last_i) + 1) % n_p;
    dbl   = {elig_i, elig_i};
    sh    = dbl >> base;
    rot   = sh[n_p-1:0];
    any_o = |rot;
    k_sel = 0;
    for (int k = n_p - 1; k >= 0; k--)
      if (rot[k]) k_sel = k;
    id_o = id_w'((base + k_sel) % n_p);
    for (int j = 0; j < n_p; j++)
      grant_o[j] = any_o && (id_o == id_w'(j));
  end

endmodule

// File: rtl/bp_lce_req_arbiter.sv
// Shares one LCE->CCE request port among num_req_p request FSMs.
// Round-robin grant into a one-entry output register, with a per-requester
// cap on requests in flight (credits returned by done_i).
module bp_lce_req_arbiter
  import bp_common_pkg::*;
#(
  parameter int num_req_p         = 2,
  parameter int msg_width_p       = bp_lce_cce_req_width_gp,
  parameter int max_outstanding_p = 2,
  localparam int id_w  = $clog2(num_req_p),
  localparam int cnt_w = $clog2(max_outstanding_p + 1)
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic [num_req_p*msg_width_p-1:0] req_i,
  input  logic [num_req_p-1:0]             req_v_i,
  output logic [num_req_p-1:0]             req_ready_o,
  input  logic [num_req_p-1:0]             done_i,
  output logic [msg_width_p-1:0]           lce_req_o,
  output logic                             lce_req_v_o,
  input  logic                             lce_req_yumi_i,
  output logic [id_w-1:0]                  grant_id_o
);

  localparam logic [cnt_w-1:0] max_cnt = cnt_w'(max_outstanding_p);

  logic                   full_r;
  logic [msg_width_p-1:0] msg_r;
  logic [id_w-1:0]        grant_id_r, last_r;
  logic [num_req_p-1:0]   elig, pick_oh, underflow;
  logic [id_w-1:0]        pick_id;
  logic                   pick_any, space, grant;
  logic [msg_width_p-1:0] req_arr [num_req_p];

  // Per-requester credit counters; a grant and a done in the same cycle cancel
  for (genvar i = 0; i < num_req_p; i++) begin : g_cred
    logic [cnt_w-1:0] cnt_q;
    logic             inc;

    assign req_arr[i]   = req_i[i*msg_width_p +: msg_width_p];
    assign inc          = req_ready_o[i];
    assign elig[i]      = req_v_i[i] & (cnt_q < max_cnt);
    assign underflow[i] = done_i[i] & ~inc & (cnt_q == '0);

    // Count requests in flight; an unmatched done at zero is ignored
    always_ff @(posedge clk_i) begin
      if (!reset_n_i)                                cnt_q <= '0;
      else if (inc & ~done_i[i])                     cnt_q <= cnt_q + 1'b1;
      else if (~inc & done_i[i] & (cnt_q != '0))     cnt_q <= cnt_q - 1'b1;
    end
  end

  bp_rr_pick #(.n_p(num_req_p)) u_pick (
    .elig_i  (elig),
    .last_i  (last_r),
    .grant_o (pick_oh),
    .id_o    (pick_id),
    .any_o   (pick_any)
  );

  // The slot can take a new message when empty or being drained this cycle
  assign space       = ~full_r | lce_req_yumi_i;
  assign req_ready_o = (reset_n_i && space) ? pick_oh : '0;
  assign grant       = reset_n_i & space & pick_any;

  assign lce_req_o   = msg_r;
  assign lce_req_v_o = full_r;
  assign grant_id_o  = grant_id_r;

  // Output stage: capture on grant, empty on consume without refill
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      full_r     <= 1'b0;
      msg_r      <= '0;
      grant_id_r <= '0;
      last_r     <= id_w'(num_req_p - 1);
    end else if (grant) begin
      full_r     <= 1'b1;
      msg_r      <= req_arr[pick_id];
      grant_id_r <= pick_id;
      last_r     <= pick_id;
    end else if (lce_req_yumi_i) begin
      full_r     <= 1'b0;
    end
  end

  // Protocol checks: consume of an empty slot, multiple grants, credit underflow
  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(lce_req_yumi_i && !full_r)) else $error("lce_req_yumi_i while lce_req_v_o=0");
      assert ($onehot0(req_ready_o)) else $error("req_ready_o not one-hot: %b", req_ready_o);
      assert (underflow == '0) else $error("done_i with no outstanding request: %b", underflow);
    end
  end

endmodule
